// File: rtl/pc_sequencer_if.sv
// Fetch-stage PC sequencer bus: redirect requests in, fetch address and status out.
interface pc_sequencer_if #(
  parameter int unsigned ADDR_W = 30
);
  logic              stall;
  logic [ADDR_W-1:0] ctl_pc;
  logic              br_taken;
  logic [15:0]       br_offset;
  logic              j_valid;
  logic [25:0]       j_target;
  logic              jr_valid;
  logic [ADDR_W-1:0] jr_target;
  logic              exc;
  logic              eret;
  logic [ADDR_W-1:0] pc;
  logic              pc_valid;
  logic              flush;
  logic [ADDR_W-1:0] epc;

  modport master (
    output stall, ctl_pc, br_taken, br_offset, j_valid, j_target,
           jr_valid, jr_target, exc, eret,
    input  pc, pc_valid, flush, epc
  );

  modport slave (
    input  stall, ctl_pc, br_taken, br_offset, j_valid, j_target,
           jr_valid, jr_target, exc, eret,
    output pc, pc_valid, flush, epc
  );
endinterface

// File: rtl/pc_sequencer.sv
// Word-address program counter for the fetch stage: selects the next PC, holds
// redirects that arrive during a stall, and pulses flush after every redirect.
module pc_sequencer #(
  parameter int unsigned        ADDR_W    = 30,
  parameter logic [ADDR_W-1:0]  RESET_VEC = ADDR_W'(32'h0000_0000),
  parameter logic [ADDR_W-1:0]  EXC_VEC   = ADDR_W'(32'h0000_0020)
) (
  input logic            clk,
  input logic            rst_n,
  pc_sequencer_if.slave  bus
);

  localparam int unsigned OFF_W  = 16;
  localparam int unsigned JIDX_W = 26;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_epc;
  logic [ADDR_W-1:0] r_pending;
  logic              r_flush;
  logic              r_pc_valid;

  logic [ADDR_W-1:0] w_inc;
  logic [ADDR_W-1:0] w_br_tgt;
  logic [ADDR_W-1:0] w_j_tgt;
  logic [ADDR_W-1:0] w_target;
  logic              w_req;

  // Redirect targets are relative to the requesting instruction, not the fetch PC.
  assign w_inc    = bus.ctl_pc + ADDR_W'(1);
  assign w_br_tgt = w_inc + {{(ADDR_W-OFF_W){bus.br_offset[OFF_W-1]}}, bus.br_offset};
  assign w_j_tgt  = {w_inc[ADDR_W-1:JIDX_W], bus.j_target};

  // Priority select: exc > eret > jr > j > branch > sequential.
  always_comb begin
    w_req    = 1'b1;
    w_target = r_pc + ADDR_W'(1);
    if (bus.exc)           w_target = EXC_VEC;
    else if (bus.eret)     w_target = r_epc;
    else if (bus.jr_valid) w_target = bus.jr_target;
    else if (bus.j_valid)  w_target = w_j_tgt;
    else if (bus.br_taken) w_target = w_br_tgt;
    else                   w_req    = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_BOOT;
      r_pc       <= RESET_VEC;
      r_epc      <= '0;
      r_pending  <= '0;
      r_flush    <= 1'b0;
      r_pc_valid <= 1'b0;
    end else begin
      r_flush <= 1'b0;
      case (r_state)
        ST_BOOT: begin
          r_pc_valid <= 1'b1;
          r_state    <= ST_RUN;
        end
        ST_RUN: begin
          if (bus.exc) r_epc <= bus.ctl_pc;
          if (!bus.stall) begin
            r_pc    <= w_target;
            r_flush <= w_req;
          end else if (w_req) begin
            r_pending <= w_target;
            r_state   <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          // Only an exception may displace the held redirect.
          if (bus.exc) r_epc <= bus.ctl_pc;
          if (!bus.stall) begin
            r_pc    <= bus.exc ? EXC_VEC : r_pending;
            r_flush <= 1'b1;
            r_state <= ST_RUN;
          end else if (bus.exc) begin
            r_pending <= EXC_VEC;
          end
        end
        default: begin
          r_state    <= ST_BOOT;
          r_pc_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc       = r_pc;
  assign bus.pc_valid = r_pc_valid;
  assign bus.flush    = r_flush;
  assign bus.epc      = r_epc;

endmodule
